change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Parameters
REQ-001 INV_WIDTH, 8, width of each per-coin inventory counter.
REQ-002 INIT_COUNT, 10, inventory value loaded into every coin counter at reset.
REQ-003 MAX_AMOUNT, 999, largest change amount, in cents, that is accepted.

Interface
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  request to dispense changeAmount; sampled only in IDLE.
REQ-007 changeAmount  in  11  change in cents, captured on accepted start.
REQ-008 coinReady  in  1  coin mechanism accepts the presented coin this cycle.
REQ-009 restockEn  in  1  add restockCount to the counter selected by restockType.
REQ-010 restockType  in  2  0 nickel, 1 dime, 2 quarter, 3 dollar.
REQ-011 restockCount  in  INV_WIDTH  number of coins to add.
REQ-012 coinValid  out  1  coinType is presented to the mechanism.
REQ-013 coinType  out  2  coin being dispensed, same encoding as restockType.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse when remaining reaches 0.
REQ-016 fault  out  1  sticky flag; set on shortfall or invalid amount, cleared on the next accepted start.
REQ-017 remaining  out  11  cents not yet dispensed.
REQ-018 invNickel, invDime, invQuarter, invDollar  out  INV_WIDTH  current inventory counts.

Function
REQ-019 The FSM SHALL have the states IDLE, SELECT, ISSUE, DONE and FAULT.
REQ-020 IDLE: start=1 SHALL capture changeAmount into remaining and clear fault.
  - Amount valid (≤MAX_AMOUNT and a multiple of 5): next state SELECT.
  - Amount invalid: next state FAULT, and remaining holds the captured amount.
REQ-021 start SHALL be ignored whenever the FSM is not in IDLE.
REQ-022 SELECT SHALL, within one cycle, choose the largest coin value (100, 25, 10, 5) that is ≤ remaining and has a nonzero inventory.
  - A coin is found: next state ISSUE, with the chosen coin latched into coinType.
  - remaining==0: next state DONE.
  - No usable coin: next state FAULT.
REQ-023 ISSUE SHALL hold coinValid=1 with coinType stable until coinReady=1.
  - Transfer cycle (coinValid & coinReady): remaining decrements by the coin value, that coin's inventory decrements by 1, and the next state is SELECT.
REQ-024 coinValid SHALL be 0 in every state other than ISSUE.
REQ-025 Latency: coinValid SHALL first rise 2 cycles after the accepted start, and consecutive coins SHALL be at least 2 cycles apart.
REQ-026 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE.
  - start with amount 0 gives done 2 cycles after start, with no coins dispensed.
REQ-027 FAULT SHALL set fault=1 for one cycle in the state and then return to IDLE; the fault output stays high and remaining keeps the undispensed amount.
REQ-028 restockEn SHALL be applied only in IDLE, with the sum saturating at 2^INV_WIDTH-1; it is ignored while busy.
REQ-029 Inventory SHALL never underflow; a decrement occurs only on a transfer of a coin whose count is nonzero.
REQ-030 Arithmetic: remaining SHALL be 11-bit unsigned and SHALL never go negative, because a coin is chosen only if its value ≤ remaining.

Reset
REQ-031 rst SHALL force, on the next edge, irrespective of current state (including mid-ISSUE):
  - state=IDLE;
  - coinValid=0, coinType=0, busy=0, done=0, fault=0, remaining=0;
  - all inventory counters=INIT_COUNT.
REQ-032 A coin whose transfer had not completed when rst was applied SHALL not be counted.

Verification
REQ-033 Full inventory (10 each), start with amount 65, coinReady=1 -> coins 2,2,1,0 (quarter, quarter, dime, nickel); done pulse; remaining=0; invQuarter=8, invDime=9, invNickel=9.
REQ-034 invQuarter=0, start with amount 30 -> dime ×3; done; invDime=7.
REQ-035 Only invDime=1 and invNickel=0 (others 0), start with amount 15 -> one dime, then FAULT; fault=1, remaining=5, no done.
REQ-036 start with amount 7, and separately with amount 1000 -> FAULT next cycle; no coinValid; remaining holds the amount; fault=1.
REQ-037 Backpressure: coinReady low for 3 cycles during ISSUE -> coinValid and coinType stable; remaining changes only on the transfer cycle. Also, start pulsed while busy -> ignored.
REQ-038 Edge cases:
  - rst asserted mid-ISSUE -> next cycle IDLE, outputs at reset values, inventories=10.
  - restockEn with type 3 and count 250 on a full counter (10) -> invDollar=255 (saturated).

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin-change FSM with per-coin inventory and restock
module change_dispenser #(
   parameter int INV_WIDTH  = 8,
   parameter int INIT_COUNT = 10,
   parameter int MAX_AMOUNT = 999
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [10:0]          changeAmount,
   input  logic                 coinReady,
   input  logic                 restockEn,
   input  logic [1:0]           restockType,
   input  logic [INV_WIDTH-1:0] restockCount,
   output logic                 coinValid,
   output logic [1:0]           coinType,
   output logic                 busy,
   output logic                 done,
   output logic                 fault,
   output logic [10:0]          remaining,
   output logic [INV_WIDTH-1:0] invNickel,
   output logic [INV_WIDTH-1:0] invDime,
   output logic [INV_WIDTH-1:0] invQuarter,
   output logic [INV_WIDTH-1:0] invDollar
);
   typedef enum logic [2:0] {IDLE, SELECT, ISSUE, DONE, FAULT} state_t;
   localparam logic [10:0] MAX_AMT = 11'(MAX_AMOUNT);
   state_t               r_state;
   logic                 r_coin_valid, r_busy, r_done, r_fault;
   logic [1:0]           r_coin_type;
   logic [10:0]          r_remaining;
   logic [INV_WIDTH-1:0] r_inv [4];
   logic [3:0]           w_ok;
   logic [1:0]           w_sel;
   logic [10:0]          w_val;
   logic                 w_valid;
   logic [INV_WIDTH:0]   w_sum;
   logic [INV_WIDTH-1:0] w_sat;
   // a coin qualifies only if it fits in remaining, so remaining never underflows
   assign w_ok[3] = r_remaining >= 11'd100 && r_inv[3] != '0;
   assign w_ok[2] = r_remaining >= 11'd25  && r_inv[2] != '0;
   assign w_ok[1] = r_remaining >= 11'd10  && r_inv[1] != '0;
   assign w_ok[0] = r_remaining >= 11'd5   && r_inv[0] != '0;
   assign w_sel   = w_ok[3] ? 2'd3 : w_ok[2] ? 2'd2 : w_ok[1] ? 2'd1 : 2'd0;
   assign w_val   = r_coin_type == 2'd3 ? 11'd100 : r_coin_type == 2'd2 ? 11'd25 :
                    r_coin_type == 2'd1 ? 11'd10 : 11'd5;
   assign w_valid = changeAmount <= MAX_AMT && changeAmount % 11'd5 == 11'd0;
   assign w_sum   = {1'b0, r_inv[restockType]} + {1'b0, restockCount};
   assign w_sat   = w_sum[INV_WIDTH] ? '1 : w_sum[INV_WIDTH-1:0];
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_coin_valid <= 1'b0;
         r_coin_type  <= 2'd0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_fault      <= 1'b0;
         r_remaining  <= 11'd0;
         for (int i = 0; i < 4; i++) r_inv[i] <= INV_WIDTH'(INIT_COUNT);
      end else begin
         case (r_state)
            IDLE: begin
               if (restockEn) r_inv[restockType] <= w_sat;
               if (start) begin
                  r_remaining <= changeAmount;
                  r_fault     <= !w_valid;
                  r_busy      <= 1'b1;
                  r_state     <= w_valid ? SELECT : FAULT;
               end
            end
            SELECT: begin
               if (r_remaining == 11'd0) begin
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else if (|w_ok) begin
                  r_coin_type  <= w_sel;
                  r_coin_valid <= 1'b1;
                  r_state      <= ISSUE;
               end else begin
                  r_fault <= 1'b1;
                  r_state <= FAULT;
               end
            end
            ISSUE: begin
               if (coinReady) begin
                  r_remaining  <= r_remaining - w_val;
                  r_coin_valid <= 1'b0;
                  r_state      <= SELECT;
                  if (r_inv[r_coin_type] != '0) r_inv[r_coin_type] <= r_inv[r_coin_type] - 1'b1;
               end
            end
            DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end
   assign coinValid  = r_coin_valid;
   assign coinType   = r_coin_type;
   assign busy       = r_busy;
   assign done       = r_done;
   assign fault      = r_fault;
   assign remaining  = r_remaining;
   assign invNickel  = r_inv[0];
   assign invDime    = r_inv[1];
   assign invQuarter = r_inv[2];
   assign invDollar  = r_inv[3];
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: directed vectors against hand-computed coin sequences and inventories
module tb_change_dispenser;
   logic        clk = 0, rst = 1, start = 0, coinReady = 0, restockEn = 0;
   logic [10:0] changeAmount = 0;
   logic [1:0]  restockType = 0;
   logic [7:0]  restockCount = 0;
   logic        coinValid, busy, done, fault;
   logic [1:0]  coinType;
   logic [10:0] remaining;
   logic [7:0]  invNickel, invDime, invQuarter, invDollar;
   int          n_cmp = 0, n_bad = 0;
   logic [15:0] seq;
   int          n_coins, n_done;

   change_dispenser dut (
      .clk(clk), .rst(rst), .start(start), .changeAmount(changeAmount),
      .coinReady(coinReady), .restockEn(restockEn), .restockType(restockType),
      .restockCount(restockCount), .coinValid(coinValid), .coinType(coinType),
      .busy(busy), .done(done), .fault(fault), .remaining(remaining),
      .invNickel(invNickel), .invDime(invDime), .invQuarter(invQuarter), .invDollar(invDollar)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst = 1;
      tick;
      rst = 0;
   endtask

   // runs one request to completion, logging every transferred coin (2 bits each, oldest highest)
   task automatic dispense(input logic [10:0] amt);
      int cyc = 0;
      seq = 0;
      n_coins = 0;
      n_done = 0;
      changeAmount = amt;
      start = 1;
      tick;
      start = 0;
      while (busy && cyc < 200) begin
         if (coinValid && coinReady) begin
            seq = {seq[13:0], coinType};
            n_coins++;
         end
         if (done) n_done++;
         tick;
         cyc++;
      end
      check("dispense_finished", 32'(cyc < 200), 1);
   endtask

   initial begin
      tick;
      do_reset;
      check("rst_busy", busy, 0);
      check("rst_valid", coinValid, 0);
      check("rst_rem", remaining, 0);
      check("rst_fault", fault, 0);
      check("rst_done", done, 0);
      check("rst_inv", {invNickel, invDime, invQuarter, invDollar}, {8'd10, 8'd10, 8'd10, 8'd10});

      coinReady = 1;
      dispense(65);
      check("c65_coins", n_coins, 4);
      check("c65_seq", seq, 16'h00A4);
      check("c65_done", n_done, 1);
      check("c65_rem", remaining, 0);
      check("c65_inv", {invNickel, invDime, invQuarter, invDollar}, {8'd9, 8'd9, 8'd8, 8'd10});

      // latency: accepted start -> SELECT -> ISSUE
      do_reset;
      changeAmount = 5;
      start = 1;
      tick;
      start = 0;
      check("lat_sel_valid", coinValid, 0);
      check("lat_sel_busy", busy, 1);
      tick;
      check("lat_iss_valid", coinValid, 1);
      check("lat_iss_type", coinType, 0);
      tick;
      check("lat_xfer_valid", coinValid, 0);
      check("lat_xfer_rem", remaining, 0);
      tick;
      check("lat_done", done, 1);
      tick;
      check("lat_idle", {busy, done}, 0);
      changeAmount = 0;
      start = 1;
      tick;
      start = 0;
      check("zero_done_early", done, 0);
      tick;
      check("zero_done", {done, coinValid}, 2'b10);
      tick;
      check("zero_done_gone", {busy, done}, 0);
      check("zero_no_coin", invNickel, 9);

      do_reset;
      dispense(75);
      dispense(75);
      dispense(75);
      dispense(25);
      check("drain_quarter", invQuarter, 0);
      dispense(30);
      check("c30_coins", n_coins, 3);
      check("c30_seq", seq, 16'h0015);
      check("c30_done", n_done, 1);
      check("c30_dime", invDime, 7);

      do_reset;
      for (int i = 0; i < 9; i++) dispense(15);
      dispense(5);
      check("drain_dn", {invDime, invNickel}, {8'd1, 8'd0});
      dispense(15);
      check("short_coins", n_coins, 1);
      check("short_seq", seq, 1);
      check("short_done", n_done, 0);
      check("short_fault", fault, 1);
      check("short_rem", remaining, 5);
      check("short_dime", invDime, 0);

      dispense(7);
      check("inv7_coins", n_coins, 0);
      check("inv7_fault", fault, 1);
      check("inv7_rem", remaining, 7);
      changeAmount = 1000;
      start = 1;
      tick;
      start = 0;
      check("inv1000_state", {fault, coinValid, busy}, 3'b101);
      check("inv1000_rem", remaining, 1000);
      tick;
      check("inv1000_sticky", {busy, fault}, 2'b01);
      dispense(0);
      check("fault_cleared", fault, 0);
      check("zero_done_cnt", n_done, 1);

      // backpressure with an ignored start while busy
      do_reset;
      coinReady = 0;
      changeAmount = 25;
      start = 1;
      tick;
      start = 0;
      tick;
      changeAmount = 7;
      for (int i = 0; i < 3; i++) begin
         check("bp_valid", coinValid, 1);
         check("bp_type", coinType, 2);
         check("bp_rem", remaining, 25);
         start = (i == 1);
         if (i < 2) tick;
      end
      start = 0;
      coinReady = 1;
      tick;
      check("bp_xfer", {coinValid, remaining}, 0);
      check("bp_quarter", invQuarter, 9);
      tick;
      check("bp_done", done, 1);
      tick;
      check("bp_ignored", {busy, fault}, 0);

      // reset during a pending transfer
      coinReady = 0;
      changeAmount = 100;
      start = 1;
      tick;
      start = 0;
      tick;
      check("mid_issue", {coinValid, coinType}, 3'b111);
      rst = 1;
      coinReady = 1;
      tick;
      rst = 0;
      check("mid_rst_out", {coinValid, coinType, busy, done, fault}, 0);
      check("mid_rst_rem", remaining, 0);
      check("mid_rst_dollar", invDollar, 10);

      restockEn = 1;
      restockType = 3;
      restockCount = 250;
      tick;
      check("restock_sat", invDollar, 255);
      restockType = 0;
      restockCount = 5;
      tick;
      check("restock_add", invNickel, 15);
      restockEn = 0;
      coinReady = 0;
      changeAmount = 5;
      start = 1;
      tick;
      start = 0;
      restockEn = 1;
      restockType = 1;
      restockCount = 3;
      tick;
      tick;
      restockEn = 0;
      check("restock_busy", invDime, 10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
